// File: rtl/calc_cmd_initiator_if.sv
// Bus bundle for calc_cmd_initiator: command intake, calculator drive and response return.
// master = the initiator block, slave = its environment (command source, calculator, consumer).
interface calc_cmd_initiator_if #(
  parameter int unsigned TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [63:0]      cmd_a;
  logic [63:0]      cmd_b;
  logic [3:0]       cmd_mode;
  logic [TAG_W-1:0] cmd_tag;

  logic [63:0]      calc_a;
  logic [63:0]      calc_b;
  logic [3:0]       calc_mode;
  logic [63:0]      calc_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_tag, calc_result, rsp_ready,
    output cmd_ready, calc_a, calc_b, calc_mode, rsp_valid, rsp_result, rsp_tag, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_tag, calc_result, rsp_ready,
    input  cmd_ready, calc_a, calc_b, calc_mode, rsp_valid, rsp_result, rsp_tag, rsp_err
  );
endinterface

// File: rtl/calc_cmd_initiator.sv
// Calculator front end: FIFO-buffered tagged commands, fixed settle time, in-order responses.
// Optional CALC_DIV0_CHECK_EN flags mode=3 with b==0 as an error.
module calc_cmd_initiator #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TAG_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_cmd_initiator_if.master bus,
  output logic                 busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q, state_d;

  logic [63:0]      mem_a    [DEPTH];
  logic [63:0]      mem_b    [DEPTH];
  logic [3:0]       mem_mode [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [63:0]      calc_a_q, calc_b_q;
  logic [3:0]       calc_mode_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [63:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic             fifo_empty, fifo_full, push, pop, sample, rsp_done;
  logic [63:0]      head_a, head_b;
  logic [3:0]       head_mode;
  logic [TAG_W-1:0] head_tag;
  logic             head_err;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = bus.cmd_valid && !fifo_full;

  assign head_a    = mem_a[rd_ptr_q[AW-1:0]];
  assign head_b    = mem_b[rd_ptr_q[AW-1:0]];
  assign head_mode = mem_mode[rd_ptr_q[AW-1:0]];
  assign head_tag  = mem_tag[rd_ptr_q[AW-1:0]];

  always_comb begin
    head_err = (head_mode[3:2] != 2'b00);
`ifdef CALC_DIV0_CHECK_EN
    if (head_mode == 4'd3 && head_b == 64'd0) head_err = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StIssue;
      StIssue: if (cnt_q == CW'(1)) state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = fifo_empty ? StIdle : StIssue;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    sample   = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      StIdle:  pop = !fifo_empty;
      StIssue: sample = (cnt_q == CW'(1));
      StResp: begin
        rsp_done = bus.rsp_ready;
        pop      = bus.rsp_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q[AW-1:0]]    <= bus.cmd_a;
      mem_b[wr_ptr_q[AW-1:0]]    <= bus.cmd_b;
      mem_mode[wr_ptr_q[AW-1:0]] <= bus.cmd_mode;
      mem_tag[wr_ptr_q[AW-1:0]]  <= bus.cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      calc_a_q     <= '0;
      calc_b_q     <= '0;
      calc_mode_q  <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        calc_a_q    <= head_a;
        calc_b_q    <= head_b;
        calc_mode_q <= head_mode;
        tag_q       <= head_tag;
        err_q       <= head_err;
        cnt_q       <= CW'(SETTLE_CYCLES);
      end else if (state_q == StIssue) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (sample) begin
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= err_q ? 64'd0 : bus.calc_result;
        rsp_tag_q    <= tag_q;
        rsp_err_q    <= err_q;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.calc_a     = calc_a_q;
  assign bus.calc_b     = calc_b_q;
  assign bus.calc_mode  = calc_mode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_calc_cmd_initiator.sv
// Bench for calc_cmd_initiator: directed steps plus randomized traffic against a queue model.
module tb_calc_cmd_initiator;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned TAG_W  = 4;
  localparam logic [63:0] DIV0_VAL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BAD_VAL  = 64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  calc_cmd_initiator_if #(.TAG_W(TAG_W)) bus ();

  calc_cmd_initiator #(
    .DEPTH(DEPTH),
    .SETTLE_CYCLES(SETTLE),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural calculator seen by the DUT.
  function automatic logic [63:0] calc_fn(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] mode);
    case (mode)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 64'd0) ? DIV0_VAL : a / b;
      default: return BAD_VAL;
    endcase
  endfunction

  assign bus.calc_result = calc_fn(bus.calc_a, bus.calc_b, bus.calc_mode);

  function automatic rsp_t ref_rsp(input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] mode, input logic [TAG_W-1:0] tag);
    rsp_t r;
    logic err;
    err = (mode > 4'd3);
`ifdef CALC_DIV0_CHECK_EN
    if (mode == 4'd3 && b == 64'd0) err = 1'b1;
`endif
    r.err = err;
    r.tag = tag;
    r.res = err ? 64'd0 : calc_fn(a, b, mode);
    return r;
  endfunction

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_fire = -1;
  bit   track_gap = 1'b0;
  bit   stalled = 1'b0;
  rsp_t q[$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Scoreboard the current cycle's handshakes, then advance to the next negedge.
  task automatic tick();
    rsp_t exp;
    if (rst_n) begin
      if (stalled) check("stall_keeps_valid", bus.rsp_valid, 1);
      if (q.size() == 0) begin
        check("no_unexpected_rsp", bus.rsp_valid, 0);
      end else if (bus.rsp_valid) begin
        exp = q[0];
        check("rsp_result", bus.rsp_result, exp.res);
        check("rsp_tag", bus.rsp_tag, exp.tag);
        check("rsp_err", bus.rsp_err, exp.err);
        if (bus.rsp_ready) begin
          void'(q.pop_front());
          if (track_gap && last_fire >= 0) check("rsp_gap", cyc - last_fire, SETTLE + 1);
          last_fire = cyc;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready)
        q.push_back(ref_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_mode, bus.cmd_tag));
    end
    stalled = rst_n && bus.rsp_valid && !bus.rsp_ready;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_cmd(input logic [63:0] a, input logic [63:0] b, input logic [3:0] mode,
                          input logic [TAG_W-1:0] tag);
    bit ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_mode  = mode;
    bus.cmd_tag   = tag;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_mode  = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_calc_a", bus.calc_a, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    rst_n = 1'b1;
    tick();

    // Add 5+7 with an empty pipeline: calc_* after k+1, response after k+1+SETTLE.
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 64'd5;
    bus.cmd_b     = 64'd7;
    bus.cmd_mode  = 4'd0;
    bus.cmd_tag   = 4'd3;
    check("add_cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("add_calc_a", bus.calc_a, 5);
    check("add_calc_b", bus.calc_b, 7);
    check("add_calc_mode", bus.calc_mode, 0);
    check("add_not_yet_valid", bus.rsp_valid, 0);
    check("add_busy", busy, 1);
    repeat (SETTLE) tick();
    check("add_rsp_valid", bus.rsp_valid, 1);
    check("add_rsp_result", bus.rsp_result, 12);
    check("add_rsp_tag", bus.rsp_tag, 3);
    check("add_rsp_err", bus.rsp_err, 0);
    bus.rsp_ready = 1'b1;
    tick();
    check("add_rsp_done", bus.rsp_valid, 0);

    push_cmd(64'd1, 64'd1, 4'd9, 4'd5);
    drain();
    push_cmd(64'd100, 64'd0, 4'd3, 4'd6);
    drain();
    tick();
    check("idle_busy", busy, 0);

    // Backpressure: 4 in the FIFO plus one held in the response stage.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = {$urandom(), $urandom()};
      bus.cmd_b     = {$urandom(), $urandom()};
      bus.cmd_mode  = 4'($urandom_range(0, 3));
      bus.cmd_tag   = TAG_W'(i);
      check("bp_cmd_ready", bus.cmd_ready, (i < 5));
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    check("bp_busy", busy, 1);
    check("bp_valid_held", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    drain();

    // Reset while the second command is settling with two more queued.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 64'(i + 20);
      bus.cmd_b     = 64'd3;
      bus.cmd_mode  = 4'd2;
      bus.cmd_tag   = TAG_W'(i + 8);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    q.delete();
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_calc_a", bus.calc_a, 0);
    check("mid_rst_calc_b", bus.calc_b, 0);
    check("mid_rst_calc_mode", bus.calc_mode, 0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("dropped_no_rsp", bus.rsp_valid, 0);
      tick();
    end

    // Streaming with rsp_ready held high: one response every SETTLE+1 cycles.
    track_gap = 1'b1;
    last_fire = -1;
    push_cmd(64'd3, 64'd4, 4'd2, 4'd1);
    push_cmd(64'd10, 64'd15, 4'd1, 4'd2);
    push_cmd(64'd40, 64'd2, 4'd0, 4'd3);
    push_cmd(64'd100, 64'd7, 4'd3, 4'd4);
    for (int i = 0; i < 4; i++)
      push_cmd({$urandom(), $urandom()}, 64'($urandom_range(1, 1000)),
               4'($urandom_range(0, 3)), TAG_W'(i + 5));
    drain();
    track_gap = 1'b0;

    // Random traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_a     = ($urandom_range(0, 1) != 0) ? {$urandom(), $urandom()}
                                                  : 64'($urandom_range(0, 50));
      bus.cmd_b     = ($urandom_range(0, 5) == 0) ? 64'd0 : {32'd0, $urandom()};
      bus.cmd_mode  = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
      bus.cmd_tag   = TAG_W'($urandom());
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
